cal_lut_tx: RTL and testbench
=============================

# cal_lut_tx

Transmitter for the temperature sensor's serial calibration-LUT load port. Holds a local copy of the 32-entry × 6-bit calibration table, written by a parallel register interface. On command, it shifts the whole table out as 192 bits on `cal_clk`/`cal_dat`, then drives `cal_ena`. It sits on the host/harness side of the sensor's `cal_clk`, `cal_dat` and `cal_ena` pins, so the sensor's LUT can be reloaded without manual dipswitch clocking.

## Interface
- `N_VDAC`, default 6: result width. Entries = 2**(N_VDAC-1) = 32; frame length = 6×32 = 192 bits.
- `CLK_DIV`, default 4: `clk` cycles per `cal_clk` half-period. Must be ≥1.
- `clk` input 1: system clock. All logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: table write strobe.
- `wr_addr` input N_VDAC-1: entry index, 0..31.
- `wr_data` input N_VDAC: entry value.
- `start` input 1: single-cycle request to transmit the frame.
- `ena_req` input 1: calibration is requested to be active after load.
- `busy` output 1: frame transmission in progress.
- `done` output 1: one-cycle pulse when the frame completes.
- `cal_clk` output 1: serial shift clock to the sensor. The sensor captures on the rising edge.
- `cal_dat` output 1: serial data to the sensor.
- `cal_ena` output 1: calibration enable to the sensor.

## Operation
- Reset (asynchronous, immediate): state IDLE; `busy`, `done`, `cal_clk`, `cal_dat`, `cal_ena` = 0; `loaded` = 0; bit counter = 0; divider = 0. Table contents are set per Configuration.
- Table write: accepted only when `busy`=0, written as table[`wr_addr`] <= `wr_data`. Writes while `busy`=1 are ignored.
- Bit order: the sensor shifts left, and entry i occupies bits [6i+5:6i]. Transmit order is therefore entry 31 bit 5 first, then down to entry 0 bit 0 last. Serial bit index b = 191..0 carries table[b/6][b%6].
- Frame transmission is a state machine with states IDLE, LOW, HIGH, FIN:
  - IDLE: `start`=1 → LOW with b=191, `busy`=1, `cal_ena`=0, `cal_dat`=bit 191.
  - LOW: `cal_clk`=0, `cal_dat` stable for CLK_DIV cycles, then → HIGH.
  - HIGH: `cal_clk`=1, `cal_dat` unchanged, for CLK_DIV cycles. At the end, if b=0 → FIN; otherwise b←b-1 and → LOW with `cal_dat` set to the new bit.
  - FIN: one cycle with `cal_clk`=0. `done`=1, `busy`=0, `loaded`=1 on exit, → IDLE.
- `cal_dat` changes only on the cycle that enters LOW, so it never changes while `cal_clk`=1.
- `start` while `busy`=1 is ignored; it is not queued.
- A write in the same cycle as `start` (both accepted, `busy`=0) is applied, and the new value is transmitted.
- `cal_ena` is a registered copy of (`ena_req` & `loaded` & !`busy`). It is forced low during the whole frame, because the sensor LUT is inconsistent mid-shift.
- Reset mid-frame aborts immediately. `loaded` is cleared, so `cal_ena` stays 0 until a complete frame has been sent.
- Table readback is not provided.

## Timing
- `start` sampled at edge k → `busy`=1, `cal_clk`=0, and `cal_dat`=bit 191 after edge k.
- First `cal_clk` rise after edge k+CLK_DIV.
- Each bit lasts 2×CLK_DIV cycles. `busy` is high for 192×2×CLK_DIV + 1 cycles. For CLK_DIV=4 that is 1537.
- `done` is high in the single cycle after the last `cal_clk` fall. `busy` is already 0 in that cycle.
- `cal_ena` rises one cycle after `done` if `ena_req`=1. It follows `ena_req` with one cycle of latency while idle.
- There are exactly 192 `cal_clk` rising edges per frame, with no glitches. `cal_clk` idles at 0.

## Configuration
- `CAL_TX_IDENTITY_INIT_EN`:
  - Defined: reset loads table[i] = i for i = 0..31, so an unwritten frame is an identity calibration.
  - Undefined: reset clears every table entry to 0. The table can then be plain registers without reset-value muxing. All other behaviour is identical.

## Test plan
- Write table[31]=6'h2A, table[0]=6'h15, others 0, CLK_DIV=1, pulse `start`. Capture `cal_dat` on each `cal_clk` rise. Expected: exactly 192 bits; the first six are 1,0,1,0,1,0; the last six are 0,1,0,1,0,1. `busy` is high for 385 cycles, then a single `done` pulse.
- Shadow-model check: mirror the sensor's receive register (a 192-bit shift register clocked by `cal_clk`) and load random table contents. After `done`, every mirrored entry i equals table[i].
- `ena_req`=1 held throughout: `cal_ena`=0 from reset until one cycle after the first `done`. `cal_ena` drops the cycle after a second `start` and returns after that frame's `done`.
- During a frame, `wr_en` to entry 5 with 6'h3F and a second `start` pulse: the table entry is unchanged, no second frame starts, and the rising-edge count stays 192.
- Assert `reset_n`=0 at bit 100 of a frame: all outputs are 0 asynchronously. After release, `cal_ena`=0 even with `ena_req`=1, until a full frame completes.
- Without writes after reset: with `CAL_TX_IDENTITY_INIT_EN` the mirrored entries equal 0..31; without the macro they are all 0.

Source files
------------

// File: rtl/cal_lut_tx.sv
// Serial calibration-LUT transmitter: local 32x6 table shifted out on cal_clk/cal_dat.
// Define CAL_TX_IDENTITY_INIT_EN to reset the table to table[i] = i instead of 0.
module cal_lut_tx #(
  parameter int N_VDAC  = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [N_VDAC-2:0] wr_addr,
  input  logic [N_VDAC-1:0] wr_data,
  input  logic              start,
  input  logic              ena_req,
  output logic              busy,
  output logic              done,
  output logic              cal_clk,
  output logic              cal_dat,
  output logic              cal_ena
);

  localparam int ENT = 2 ** (N_VDAC - 1);
  localparam int EW  = N_VDAC - 1;
  localparam int SW  = $clog2(N_VDAC);
  localparam int DW  = $clog2(CLK_DIV + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]        state;
  logic [DW-1:0]     div;
  logic [EW-1:0]     ent;
  logic [SW-1:0]     sb;
  logic              loaded;
  logic [N_VDAC-1:0] tbl [ENT];

  logic          go;
  logic          wr_ok;
  logic          div_end;
  logic          first_bit;
  logic [EW-1:0] ent_nx;
  logic [SW-1:0] sb_nx;

  assign go      = (state == IDLE) && start;
  assign wr_ok   = wr_en && !busy;
  assign div_end = (div == DW'(CLK_DIV - 1));

  // A write landing with start must be visible in the very first bit.
  assign first_bit = (wr_ok && wr_addr == EW'(ENT - 1))
                   ? wr_data[N_VDAC-1]
                   : tbl[ENT-1][N_VDAC-1];

  always_comb begin
    sb_nx  = sb - 1'b1;
    ent_nx = ent;
    if (sb == '0) begin
      sb_nx  = SW'(N_VDAC - 1);
      ent_nx = ent - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENT; i++) begin
`ifdef CAL_TX_IDENTITY_INIT_EN
        tbl[i] <= N_VDAC'(i);
`else
        tbl[i] <= '0;
`endif
      end
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div     <= '0;
      ent     <= '0;
      sb      <= '0;
      loaded  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cal_clk <= 1'b0;
      cal_dat <= 1'b0;
      cal_ena <= 1'b0;
    end else begin
      done    <= 1'b0;
      cal_ena <= go ? 1'b0 : (ena_req && loaded && !busy);
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOW;
            busy    <= 1'b1;
            div     <= '0;
            ent     <= EW'(ENT - 1);
            sb      <= SW'(N_VDAC - 1);
            cal_clk <= 1'b0;
            cal_dat <= first_bit;
          end
        end
        LOW: begin
          if (div_end) begin
            div     <= '0;
            state   <= HIGH;
            cal_clk <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div     <= '0;
            cal_clk <= 1'b0;
            if (ent == '0 && sb == '0) begin
              state <= FIN;
            end else begin
              state   <= LOW;
              ent     <= ent_nx;
              sb      <= sb_nx;
              cal_dat <= tbl[ent_nx][sb_nx];
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          loaded <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_lut_tx.sv
// Bench for cal_lut_tx: mirrors the sensor receive register and checks
// frames against a table model, plus ena gating, busy lockout and reset abort.
module tb_cal_lut_tx;

  localparam int D = 2;

  logic       clk = 0;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [5:0] wr_data;
  logic       start;
  logic       ena_req;
  logic       busy, done, cal_clk, cal_dat, cal_ena;

  int checks = 0;
  int errors = 0;

  logic [5:0]   tbl_m [32];
  logic [191:0] rx = '0;
  int           rises = 0;
  int           glitch = 0;
  logic         pclk = 0, pdat = 0;

  cal_lut_tx #(.N_VDAC(6), .CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .ena_req(ena_req), .busy(busy), .done(done),
    .cal_clk(cal_clk), .cal_dat(cal_dat), .cal_ena(cal_ena)
  );

  always #5 clk = ~clk;

  // sensor-side receive register: shifts left on each cal_clk rise
  always @(posedge cal_clk) begin
    rx    <= {rx[190:0], cal_dat};
    rises <= rises + 1;
  end

  always @(negedge clk) begin
    if (pclk && cal_clk && (cal_dat !== pdat)) glitch <= glitch + 1;
    pclk <= cal_clk;
    pdat <= cal_dat;
  end

  task automatic chk(input string tag, input logic [191:0] o,
                     input logic [191:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 32; i++) begin
`ifdef CAL_TX_IDENTITY_INIT_EN
      tbl_m[i] = 6'(i);
`else
      tbl_m[i] = 6'd0;
`endif
    end
  endtask

  function automatic logic [191:0] exp_frame();
    logic [191:0] v;
    for (int i = 0; i < 32; i++) v[6*i +: 6] = tbl_m[i];
    return v;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = d;
    tbl_m[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic send(input bit jw, input logic [4:0] a,
                      input logic [5:0] d, input bit junk);
    int base, bc, g;
    logic [191:0] e;
    @(negedge clk);
    start = 1;
    if (jw) begin
      wr_en = 1; wr_addr = a; wr_data = d;
      tbl_m[a] = d;
    end
    e = exp_frame();
    base = rises;
    @(negedge clk);
    start = 0; wr_en = 0;
    chk("start_busy", busy, 1);
    chk("start_dat", cal_dat, e[191]);
    chk("start_clk", cal_clk, 0);
    chk("start_ena", cal_ena, 0);
    bc = 1; g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
      start = 0; wr_en = 0;
      if (busy) bc++;
      if (junk && bc == 50) begin
        wr_en = 1; wr_addr = 5; wr_data = 6'h3F; start = 1;
      end
    end
    chk("busy_len", bc, 384 * D + 1);
    chk("done_hi", done, 1);
    chk("rises", rises - base, 192);
    chk("frame", rx, e);
    chk("ena_in_done", cal_ena, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ena_after", cal_ena, ena_req);
  endtask

  initial begin
    int base, g;
    reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    start = 0; ena_req = 1;
    init_model();
    repeat (2) @(negedge clk);
    chk("reset_out", {busy, done, cal_clk, cal_dat, cal_ena}, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("ena_pre_load", cal_ena, 0);

    send(0, 0, 0, 0);

    for (int i = 0; i < 32; i++) wr(5'(i), 6'd0);
    wr(31, 6'h2A);
    wr(0, 6'h15);
    send(0, 0, 0, 0);
    chk("first6", rx[191:186], 6'b101010);
    chk("last6", rx[5:0], 6'b010101);

    ena_req = 0;
    @(negedge clk);
    chk("ena_follow0", cal_ena, 0);
    ena_req = 1;
    @(negedge clk);
    chk("ena_follow1", cal_ena, 1);

    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 32; i++) wr(5'(i), 6'($urandom));
      send(0, 0, 0, it == 0);
      repeat (5) @(negedge clk);
      chk("no_requeue", busy, 0);
    end
    send(0, 0, 0, 0);

    send(1, 31, 6'($urandom_range(32, 63)), 0);

    @(negedge clk);
    start = 1;
    base = rises;
    @(negedge clk);
    start = 0;
    g = 0;
    while ((rises - base) < 92 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("mid_reach", rises - base, 92);
    chk("mid_busy", busy, 1);
    #1 reset_n = 0;
    #1 chk("async_rst", {busy, done, cal_clk, cal_dat, cal_ena}, 0);
    init_model();
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("ena_after_rst", cal_ena, 0);
    send(0, 0, 0, 0);

    chk("no_glitch", glitch, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
